// File: rtl/expr_str_gen_if.sv
// Expression-string bus: parameter load/start on one side, ASCII char stream out.
// Latency: n/a (signal bundle only).
// Backpressure: out_valid/out_ready handshake on the character stream. Optional `result` with EXPR_STR_GEN_EVAL_EN.
`timescale 1ns/1ps
interface expr_str_gen_if #(
    parameter int N_MAX = 8
`ifdef EXPR_STR_GEN_EVAL_EN
    , parameter int RES_W = 16
`endif
);
    logic                 start;
    logic [4:0]           len;
    logic [4*N_MAX-1:0]   digits;
    logic [N_MAX-2:0]     ops;
    logic [7:0]           out_char;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef EXPR_STR_GEN_EVAL_EN
    logic [RES_W-1:0]     result;

    modport master (input start, len, digits, ops, out_ready,
                    output out_char, out_valid, busy, done, err, result);
    modport slave  (output start, len, digits, ops, out_ready,
                    input out_char, out_valid, busy, done, err, result);
`else
    modport master (input start, len, digits, ops, out_ready,
                    output out_char, out_valid, busy, done, err);
    modport slave  (output start, len, digits, ops, out_ready,
                    input out_char, out_valid, busy, done, err);
`endif
endinterface

// File: rtl/expr_str_gen.sv
// Emits "d op d op ... d" as ASCII, one char per accepted handshake; optional evaluator (EXPR_STR_GEN_EVAL_EN).
// Latency: first char valid the cycle after start is accepted; done the cycle after the last accept.
// Backpressure: out_char/out_valid hold while out_ready is low; stream simply stalls.
`timescale 1ns/1ps
module expr_str_gen #(
    parameter int N_MAX = 8
`ifdef EXPR_STR_GEN_EVAL_EN
    , parameter int RES_W = 16
`endif
) (
    input  logic           clk,
    input  logic           clr,
    expr_str_gen_if.master bus
);
    localparam int IW = $clog2(N_MAX);

    typedef enum logic [1:0] {IDLE, DIG, OP, FIN} state_t;

    state_t         state;
    logic [3:0]     dig_r [N_MAX];
    // opsx_r[i] is the operator in front of digit i; bit 0 is a fake '+'
    logic [N_MAX-1:0] opsx_r;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  last_r;
    logic [IW-1:0]  nidx;
    logic           bad_digit;
    logic           params_ok;
    logic           accept;

    function automatic logic [7:0] dig_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic mul);
        return mul ? 8'h2A : 8'h2B;
    endfunction

    // Start validation and handshake decode
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < N_MAX; i++) begin
            if (5'(i) < bus.len && bus.digits[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
        params_ok = (bus.len != 5'd0) && (bus.len <= 5'(N_MAX)) && !bad_digit;
        nidx      = idx + IW'(1);
        accept    = bus.out_valid && bus.out_ready;
    end

`ifdef EXPR_STR_GEN_EVAL_EN
    logic [RES_W-1:0] prod;
    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] cur_ext;
    logic [RES_W-1:0] new_prod;

    // Product term after folding in the digit currently on the bus
    always_comb begin
        cur_ext  = RES_W'(dig_r[idx]);
        new_prod = opsx_r[idx] ? prod * cur_ext : cur_ext;
    end
`endif

    // Sequencer: IDLE -> DIG <-> OP -> FIN -> IDLE, all outputs registered
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            idx           <= '0;
            last_r        <= '0;
            opsx_r        <= '0;
            for (int i = 0; i < N_MAX; i++) dig_r[i] <= 4'h0;
            bus.out_char  <= 8'h00;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
`ifdef EXPR_STR_GEN_EVAL_EN
            prod          <= '0;
            sum           <= '0;
            bus.result    <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (params_ok) begin
                            for (int i = 0; i < N_MAX; i++) dig_r[i] <= bus.digits[4*i +: 4];
                            opsx_r        <= {bus.ops, 1'b0};
                            idx           <= '0;
                            last_r        <= IW'(bus.len - 5'd1);
                            bus.out_char  <= dig_char(bus.digits[3:0]);
                            bus.out_valid <= 1'b1;
                            bus.busy      <= 1'b1;
                            state         <= DIG;
`ifdef EXPR_STR_GEN_EVAL_EN
                            prod          <= '0;
                            sum           <= '0;
                            bus.result    <= '0;
`endif
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                DIG: begin
                    if (accept) begin
`ifdef EXPR_STR_GEN_EVAL_EN
                        prod <= new_prod;
`endif
                        if (idx == last_r) begin
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= FIN;
`ifdef EXPR_STR_GEN_EVAL_EN
                            bus.result    <= sum + new_prod;
`endif
                        end else begin
                            bus.out_char <= op_char(opsx_r[nidx]);
                            state        <= OP;
                        end
                    end
                end
                OP: begin
                    if (accept) begin
`ifdef EXPR_STR_GEN_EVAL_EN
                        if (!opsx_r[nidx]) sum <= sum + prod;
`endif
                        idx          <= nidx;
                        bus.out_char <= dig_char(dig_r[nidx]);
                        state        <= DIG;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/expr_str_gen.md
# expr_str_gen

Generates the ASCII character stream of an arithmetic expression, one character per handshake: `digit op digit op … digit`, with digits `'0'`–`'9'` and operators `'+'`/`'*'`. It is the transmitter end of the expression-string interface consumed by the `string` validator. Its `out_char` is cycle-compatible with that validator's `in` port, so it can drive it directly in self-checking benches and on-board demos. An optional evaluator also reports the numeric value with standard precedence.

## Interface
- `N_MAX`, 8, maximum digits per expression (2..16)
- `RES_W`, 16, width of evaluated result

- `clk` input 1: rising-edge clock
- `clr` input 1: reset, asynchronous, active-high
- `start` input 1: request to emit loaded expression; sampled only in IDLE
- `len` input 5: number of digits, 1..N_MAX
- `digits` input 4*N_MAX: digit i at [4i+3:4i]; digit 0 is emitted first
- `ops` input N_MAX-1: bit i is the operator between digit i and digit i+1; 0=`'+'`, 1=`'*'`
- `out_char` output 8: current ASCII character
- `out_valid` output 1: `out_char` is valid
- `out_ready` input 1: consumer accepts `out_char` this cycle
- `busy` output 1: high from start acceptance until `done`
- `done` output 1: one-cycle pulse after the last character is accepted
- `err` output 1: one-cycle pulse when `start` is rejected
- `result` output RES_W: evaluated value (only with `EXPR_STR_GEN_EVAL_EN`)

## Operation
- States: IDLE, DIG, OP, FIN.
- **IDLE**
  - `start=1` with valid parameters: capture `len`/`digits`/`ops` into internal registers, set index=0, go to DIG.
  - Invalid parameters: `len==0`, `len>N_MAX`, or any digit i<len with value >9. Pulse `err`, stay in IDLE, emit nothing.
- **DIG**
  - `out_char = 8'h30 + digit[index]`, `out_valid=1`.
  - On accept (`out_valid && out_ready`):
    - if index==len-1 → FIN;
    - else → OP.
- **OP**
  - `out_char = ops[index] ? 8'h2A : 8'h2B`, `out_valid=1`.
  - On accept: index+1, → DIG.
- **FIN**: `done=1` for one cycle, `busy=0`, → IDLE.
- Captured registers are used throughout the stream. Changes on `digits`/`ops`/`len` while busy have no effect.
- `start` while not in IDLE is ignored (no `err`).
- `out_char` and `out_valid` are stable while `out_valid && !out_ready`.

## Timing
- All outputs are registered.
- Reset values: `out_char=8'h00`, `out_valid=0`, `busy=0`, `done=0`, `err=0`, `result=0`, state=IDLE.
- Start latency:
  - `start` accepted at edge k → `out_valid=1` with the first digit after edge k, and `busy=1` in the same cycle.
  - `err` is high in the cycle after the rejected `start` edge.
- With `out_ready` held high, one character is emitted per cycle. An expression of L digits occupies 2L-1 consecutive valid cycles.
- `done` asserts in the cycle after the last character is accepted. `out_valid=0` in that cycle.
- A new `start` is accepted no earlier than the cycle after `done`, i.e. when back in IDLE.
- Asserting `clr` mid-stream immediately forces the reset values. The partial expression is abandoned and no `done` is produced.

## Configuration
- `EXPR_STR_GEN_EVAL_EN` defined: evaluator compiled in.
  - Registers `prod` and `sum` (RES_W bits, modulo 2^RES_W) are cleared at start acceptance.
  - On each accepted digit d:
    - `prod = prod*d`, or `prod = d` if it is the first digit or the previous operator was `'+'`.
  - On each accepted `'+'`: `sum = sum + prod`.
  - At FIN: `result = sum + prod`. `result` holds until the next start acceptance, when it is cleared to 0.
- Macro undefined:
  - `result` port absent.
  - No multiplier/adder logic.
  - Character stream and timing identical.

## Test plan
- **Basic:** len=3, digits 1,2,3, ops=2'b10, `out_ready=1` → `"1"`,`"+"`,`"2"`,`"*"`,`"3"` on 5 consecutive cycles. `done` on the 6th cycle. With EVAL, `result=7`.
- **Backpressure:** same expression, `out_ready` toggling 0/1 every cycle → same 5 characters, each held stable while `out_ready=0`. `done` after the last accept.
- **Single digit:** len=1, digit0=9 → single `"9"`, then `done`. With EVAL, `result=9`.
- **Rejection:**
  - digit1=12 with len=3 → `err` pulse, `out_valid` stays 0.
  - len=0 → `err`.
  - `start` while busy → ignored.
- **Overflow:** len=8, all digits 9, ops all `'*'` → 15 characters. With EVAL, `result = 9^8 mod 65536 = 55105`.
- **Reset mid-stream:** `clr=1` during the third character → all outputs 0 asynchronously, no `done`. A following start of `"2+1"` emits `"2"`,`"+"`,`"1"`, `result=3`.
